// File: rtl/niosv_key_ctrl_if.sv
// Avalon-MM slave bus bundle for the key controller.
// The CPU/interconnect side uses master; the controller uses slave.
interface niosv_key_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/niosv_key_ctrl.sv
// Debounced, interrupt-capable push-button controller on the Nios V Avalon-MM bus.
// Long-press capture (address 4) is built only when KEY_LONGPRESS_EN is defined.
module niosv_key_ctrl #(
    parameter int N_KEYS     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int TICK_DIV   = 50,
    parameter int DB_DEFAULT = 20000,
    parameter int LP_TICKS   = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    niosv_key_ctrl_if.slave   bus,
    input  logic [N_KEYS-1:0] in_port,
    output logic              irq
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [N_KEYS-1:0] RELEASED = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    logic [N_KEYS-1:0] sync1_q, sync2_q, pressed;
    logic [N_KEYS-1:0] db_q, db_d, rise;
    logic [N_KEYS-1:0] mask_q, mask_d, edgecap_q, edgecap_d;
    logic [N_KEYS-1:0] wr_bits, ec_clr, lp_rd;
    logic [15:0]       db_cnt_q [N_KEYS];
    logic [15:0]       db_cnt_d [N_KEYS];
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [15:0]       dbperiod_q, dbperiod_d;
    logic [16:0]       db_max;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d, tick, wr, lp_irq;
    logic              wd_unused;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_bits   = bus.writedata[N_KEYS-1:0];
    assign wd_unused = ^bus.writedata;

    always_comb begin
        pressed    = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        // A zero period behaves as one tick
        db_max     = (dbperiod_q == 16'd0) ? 17'd1 : {1'b0, dbperiod_q};
        db_d       = db_q;
        rise       = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            db_cnt_d[k] = db_cnt_q[k];
            if (pressed[k] == db_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (tick) begin
                if (({1'b0, db_cnt_q[k]} + 17'd1) >= db_max) begin
                    db_d[k]     = ~db_q[k];
                    db_cnt_d[k] = '0;
                    rise[k]     = ~db_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 16'd1;
                end
            end
        end

        ec_clr     = (wr && bus.address == 3'd2) ? wr_bits : '0;
        edgecap_d  = (edgecap_q & ~ec_clr) | rise;
        mask_d     = (wr && bus.address == 3'd1) ? wr_bits : mask_q;
        dbperiod_d = (wr && bus.address == 3'd3) ? bus.writedata[15:0] : dbperiod_q;
        irq_d      = (|(edgecap_q & mask_q)) | lp_irq;

        readdata_d = '0;
        case (bus.address)
            3'd0:    readdata_d[N_KEYS-1:0] = db_q;
            3'd1:    readdata_d[N_KEYS-1:0] = mask_q;
            3'd2:    readdata_d[N_KEYS-1:0] = edgecap_q;
            3'd3:    readdata_d[15:0]       = dbperiod_q;
            3'd4:    readdata_d[N_KEYS-1:0] = lp_rd;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= RELEASED;
            sync2_q    <= RELEASED;
            tick_cnt_q <= '0;
            db_q       <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            dbperiod_q <= 16'(DB_DEFAULT);
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int k = 0; k < N_KEYS; k++) db_cnt_q[k] <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            db_q       <= db_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            dbperiod_q <= dbperiod_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int k = 0; k < N_KEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
        end
    end

`ifdef KEY_LONGPRESS_EN
    localparam logic [19:0] LP_LAST = 20'(LP_TICKS - 1);

    logic [19:0]       lp_cnt_q [N_KEYS];
    logic [19:0]       lp_cnt_d [N_KEYS];
    logic [N_KEYS-1:0] lpcap_q, lpcap_d, lp_hit, lp_clr;

    // Counter saturates, so the threshold is crossed exactly once per press
    always_comb begin
        lp_hit = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            lp_cnt_d[k] = lp_cnt_q[k];
            if (!db_q[k]) begin
                lp_cnt_d[k] = '0;
            end else if (tick && (lp_cnt_q[k] != 20'hF_FFFF)) begin
                lp_cnt_d[k] = lp_cnt_q[k] + 20'd1;
                lp_hit[k]   = (lp_cnt_q[k] == LP_LAST);
            end
        end
        lp_clr  = (wr && bus.address == 3'd4) ? wr_bits : '0;
        lpcap_d = (lpcap_q & ~lp_clr) | lp_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lpcap_q <= '0;
            for (int k = 0; k < N_KEYS; k++) lp_cnt_q[k] <= '0;
        end else begin
            lpcap_q <= lpcap_d;
            for (int k = 0; k < N_KEYS; k++) lp_cnt_q[k] <= lp_cnt_d[k];
        end
    end

    assign lp_rd  = lpcap_q;
    assign lp_irq = |(lpcap_q & mask_q);
`else
    localparam int lp_ticks_unused = LP_TICKS;
    assign lp_rd  = '0;
    assign lp_irq = 1'b0;
`endif

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;
endmodule
